// File: rtl/prio_event_pkg.sv
// Shared types and constants for the priority-encoded event decoder.
package prio_event_pkg;

  localparam int unsigned DROP_W = 8;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned SUM_W  = DROP_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Number of set bits in a vector of up to 32 event lines.
  function automatic logic [CNT_W-1:0] popcount32(input logic [31:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prio_msb_index.sv
// Combinational highest-set-bit encoder: bit N-1 has top priority.
module prio_msb_index #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned W = $clog2(N);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_event_decoder.sv
// Sticky event capture drained one index at a time, highest line first,
// over a valid/ready handshake, with a saturating count of lost occurrences.
module prio_event_decoder
  import prio_event_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      evt_in,
  input  logic              clr,
  output logic              idx_valid,
  output logic [W-1:0]      idx,
  input  logic              idx_ready,
  output logic [N-1:0]      pending,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);

  state_t              state, state_next;
  logic [W-1:0]        sel_idx;
  logic                sel_any;
  logic                load;
  logic [N-1:0]        taken;
  logic [N-1:0]        drops;
  logic [N-1:0]        pending_next;
  logic [W-1:0]        idx_next;
  logic                valid_next;
  logic [DROP_W-1:0]   drop_next;
  logic                busy_next;
  logic [SUM_W-1:0]    drop_sum;

  // Selection always works on the registered pending value.
  prio_msb_index #(.N(N)) u_msb (
    .vec (pending),
    .idx (sel_idx),
    .any (sel_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    load         = 1'b0;
    taken        = '0;
    idx_next     = idx;
    valid_next   = idx_valid;
    pending_next = pending;
    drops        = '0;
    drop_sum     = '0;
    drop_next    = drop_cnt;
    busy_next    = 1'b0;

    case (state)
      IDLE: begin
        if (sel_any) begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (idx_valid && idx_ready) begin
          if (sel_any) begin
            load = 1'b1;
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      idx_next       = sel_idx;
      valid_next     = 1'b1;
      taken[sel_idx] = 1'b1;
    end

    // A bit moving to the holding register this edge may re-arm without loss.
    pending_next = (pending & ~taken) | evt_in;
    drops        = evt_in & pending & ~taken;
    drop_sum     = SUM_W'(drop_cnt) + SUM_W'(popcount32(32'(drops)));
    drop_next    = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

    if (clr) begin
      state_next   = IDLE;
      idx_next     = '0;
      valid_next   = 1'b0;
      pending_next = '0;
      drop_next    = '0;
    end

    busy_next = valid_next | (|pending_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      drop_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      pending   <= pending_next;
      idx       <= idx_next;
      idx_valid <= valid_next;
      drop_cnt  <= drop_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: doc/prio_event_decoder.md
# prio_event_decoder

Consumer side of the priority-encoded event path. The block captures up to N asynchronous-to-software event lines into a sticky pending register. It drains them one at a time as binary indices, highest bit first, over a valid/ready handshake. It turns multi-hot request vectors into a serialized stream of indices for a downstream controller, and counts events lost because their line was already pending.

## Interface
- N, default 8: number of event lines, 2..32.
- W, default $clog2(N): index width.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- evt_in  input  N  event lines, sampled every rising edge; a bit high for k cycles counts as k occurrences.
- clr  input  1  synchronous flush of pending, holding register and drop counter.
- idx_valid  output  1  idx holds a served event.
- idx  output  W  binary index of served event.
- idx_ready  input  1  downstream accepts idx.
- pending  output  N  current pending register, excluding the held bit.
- drop_cnt  output  8  saturating count of dropped occurrences.
- busy  output  1  idx_valid or any pending bit set.

Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- Reset values: pending=0, idx_valid=0, idx=0, drop_cnt=0, busy=0, FSM=IDLE.
- Capture: each edge, pending_next = (pending & ~taken) | evt_in.
  - taken is the one-hot of the bit moved to the holding register this edge, else 0.
- Drop rule: if an evt_in bit is set and the same pending bit was already set and is not being taken this edge, drop_cnt += 1 per such bit. The counter saturates at 255.
- Multiple drops in one edge add their popcount, also saturating.
- The held index does not count as pending. An event on the held line while it is held sets pending again, and this is not a drop.
- Selection: the highest set bit of pending (bit N-1 has top priority) is encoded to binary.
- FSM IDLE:
  - If pending != 0, load idx with the selected index, clear that bit via taken, set idx_valid, go to HOLD.
- FSM HOLD:
  - idx and idx_valid stay stable until idx_valid & idx_ready. A higher-priority arrival never replaces a presented index.
  - On accept with pending != 0 (after this edge's capture excluded), load the next index in the same edge and stay in HOLD.
  - On accept otherwise, clear idx_valid and go to IDLE.
- Selection for a load uses the registered pending value, not the same-edge evt_in.
- clr has priority over everything: it forces the reset values at the next edge. Events present in the clr cycle are discarded.
- busy = idx_valid | (|pending).

## Timing
- Latency: evt_in high in cycle 0 sets pending after edge E1. idx_valid is high from cycle 2 (after E2).
- Throughput: one index per cycle while idx_ready is held high and pending is non-empty.
- idx_ready with idx_valid low is ignored.
- Reset asserted mid-transfer clears all state immediately and asynchronously. The outputs follow without waiting for clk.
- Release of rst_n is synchronous to clk by the system reset synchronizer. No internal synchronization is done.

## Structure
- Package prio_event_pkg: state enum {IDLE, HOLD} and DROP_W=8.
- Sub-module prio_msb_index (parameter N): combinational highest-set-bit to binary index plus any-set flag. It is instantiated once.
- The top level holds the pending register, the holding register, the FSM and the drop counter.

## Test plan
- Reset then idle: after rst_n release with evt_in=0 for 10 cycles, idx_valid=0, busy=0 and drop_cnt=0.
- Priority drain: one-cycle pulse evt_in=8'b1010_0100 with idx_ready=1.
  - Required: idx 7, 5, 2 on consecutive cycles starting cycle 2, then idx_valid drops.
- Hold stability: pulse bit 1 with idx_ready=0 and wait for idx=1. Then pulse bit 6.
  - Required: idx stays 1 until ready.
  - Then, with ready held high, the sequence is 1, 6.
- Drop count:
  - Hold bit 3 high for 5 cycles with idx_ready=0. Expect idx=3 presented and pending[3] re-set with no drop. Then 3 drops, drop_cnt=3.
  - Hold all lines high for 300 cycles. Expect drop_cnt to saturate at 255.
- Re-arm of held line: idx=4 held, then pulse bit 4. On accept, idx=4 again is presented next cycle and drop_cnt is unchanged.
- Flush and async reset:
  - Assert clr with pending=8'hFF. Next cycle pending=0, idx_valid=0 and drop_cnt=0.
  - Pulse rst_n low mid-drain. Outputs are zero before the next clk edge.
